vcu_bram_sched: RTL and testbench

VCU_BRAM_SCHED -- requirements
Module: vcu_bram_sched

---
 rtl/vcu_bram_sched.sv | 202 ++++++++++++++++++++
 tb/tb_vcu_bram_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vcu_bram_sched.sv
// vcu_bram_sched: arbitrates one shared BRAM port between a DMA engine and a
// VCU compute core. The DMA loads operands, the VCU computes while it owns the
// BRAM, then the DMA drains the results. A watchdog bounds the compute phase.
// Ownership is decoded from the registered FSM state, so it only changes at a
// clock edge, and RESET forces the DMA to be the owner at once.
module vcu_bram_sched #(
    parameter int wordSize    = 32,
    parameter int memDepth    = 30,
    parameter int LOAD_WORDS  = 512,
    parameter int DRAIN_WORDS = 256,
    parameter int TIMEOUT     = 65535
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  start,
    input  logic                  abort,
    input  logic [memDepth+1:0]   dma_addr,
    input  logic [wordSize-1:0]   dma_wdata,
    input  logic [3:0]            dma_we,
    input  logic                  dma_en,
    output logic [wordSize-1:0]   dma_rdata,
    input  logic [memDepth+1:0]   vcu_addr,
    input  logic [wordSize-1:0]   vcu_wdata,
    input  logic [3:0]            vcu_we,
    input  logic                  vcu_en,
    output logic [wordSize-1:0]   vcu_rdata,
    output logic                  vcu_memWRTDone,
    input  logic                  vcu_done,
    output logic [memDepth+1:0]   bram_addr,
    output logic [wordSize-1:0]   bram_wdata,
    output logic [3:0]            bram_we,
    output logic                  bram_en,
    input  logic [wordSize-1:0]   bram_rdata,
    output logic [2:0]            state,
    output logic                  busy,
    output logic                  irq_done,
    output logic                  err_timeout,
    output logic                  err_conflict
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Beat-count targets narrowed to the 16-bit counter width.
    localparam logic [15:0] LOAD_CNT  = 16'(LOAD_WORDS);
    localparam logic [15:0] DRAIN_CNT = 16'(DRAIN_WORDS);
    localparam logic [31:0] TO_CNT    = 32'(TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] beat_q, beat_d;
    logic [31:0] wd_q, wd_d;
    logic        err_timeout_q, err_timeout_d;
    logic        err_conflict_q, err_conflict_d;

    logic [15:0] beat_inc_s;
    logic [31:0] wd_inc_s;
    logic        wr_beat_s;
    logic        rd_beat_s;

    // Saturating increments: the counters stick at all-ones rather than wrap.
    assign beat_inc_s = (beat_q == 16'hFFFF) ? beat_q : beat_q + 16'd1;
    assign wd_inc_s   = (wd_q == 32'hFFFF_FFFF) ? wd_q : wd_q + 32'd1;
    assign wr_beat_s  = dma_en && (dma_we != 4'd0);
    assign rd_beat_s  = dma_en && (dma_we == 4'd0);

    // State, counter and sticky-error registers; RESET clears everything at once.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q        <= ST_IDLE;
            beat_q         <= 16'd0;
            wd_q           <= 32'd0;
            err_timeout_q  <= 1'b0;
            err_conflict_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            wd_q           <= wd_d;
            err_timeout_q  <= err_timeout_d;
            err_conflict_q <= err_conflict_d;
        end
    end

    // Next-state logic: abort wins over start and vcu_done; vcu_done wins over timeout.
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        wd_d           = wd_q;
        err_timeout_d  = err_timeout_q;
        err_conflict_d = err_conflict_q;

        // A DMA access while the VCU owns the BRAM is flagged and dropped.
        if ((state_q == ST_COMPUTE) && dma_en) begin
            err_conflict_d = 1'b1;
        end else begin
            err_conflict_d = err_conflict_q;
        end

        if (abort) begin
            state_d = ST_IDLE;
            beat_d  = 16'd0;
            wd_d    = 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d        = ST_LOAD;
                        beat_d         = 16'd0;
                        err_timeout_d  = 1'b0;
                        err_conflict_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (wr_beat_s) begin
                        if (beat_inc_s == LOAD_CNT) begin
                            state_d = ST_COMPUTE;
                            beat_d  = 16'd0;
                            wd_d    = 32'd0;
                        end else begin
                            beat_d = beat_inc_s;
                        end
                    end else begin
                        beat_d = beat_q;
                    end
                end
                ST_COMPUTE: begin
                    wd_d = wd_inc_s;
                    if (vcu_done) begin
                        state_d = ST_DRAIN;
                        beat_d  = 16'd0;
                    end else if (wd_inc_s == TO_CNT) begin
                        state_d       = ST_IDLE;
                        err_timeout_d = 1'b1;
                        wd_d          = 32'd0;
                    end else begin
                        state_d = ST_COMPUTE;
                    end
                end
                ST_DRAIN: begin
                    if (rd_beat_s) begin
                        if (beat_inc_s == DRAIN_CNT) begin
                            state_d = ST_DONE;
                            beat_d  = 16'd0;
                        end else begin
                            beat_d = beat_inc_s;
                        end
                    end else begin
                        beat_d = beat_q;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    beat_d  = 16'd0;
                    wd_d    = 32'd0;
                end
            endcase
        end
    end

    // BRAM port mux: the VCU owns the BRAM only in COMPUTE; the other side sees zeros.
    always_comb begin
        bram_addr  = dma_addr;
        bram_wdata = dma_wdata;
        bram_we    = dma_we;
        bram_en    = dma_en;
        dma_rdata  = bram_rdata;
        vcu_rdata  = {wordSize{1'b0}};
        if (state_q == ST_COMPUTE) begin
            bram_addr  = vcu_addr;
            bram_wdata = vcu_wdata;
            bram_we    = vcu_we;
            bram_en    = vcu_en;
            dma_rdata  = {wordSize{1'b0}};
            vcu_rdata  = bram_rdata;
        end else begin
            bram_addr  = dma_addr;
            bram_wdata = dma_wdata;
            bram_we    = dma_we;
            bram_en    = dma_en;
            dma_rdata  = bram_rdata;
            vcu_rdata  = {wordSize{1'b0}};
        end
    end

    // Status outputs are pure decodes of registers, so RESET drops them immediately.
    assign state          = state_q;
    assign busy           = (state_q != ST_IDLE);
    assign irq_done       = (state_q == ST_DONE);
    assign vcu_memWRTDone = (state_q == ST_COMPUTE);
    assign err_timeout    = err_timeout_q;
    assign err_conflict   = err_conflict_q;

endmodule

// File: tb/tb_vcu_bram_sched.sv
// Self-checking bench for vcu_bram_sched: a main instance with default
// parameters and a small instance (TIMEOUT=10) for the watchdog path.
module tb_vcu_bram_sched;
    localparam int WS = 32;
    localparam int MD = 30;
    localparam int AW = MD + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          RESET, start, abort, dma_en, vcu_en, vcu_done;
    logic [AW-1:0] dma_addr, vcu_addr, bram_addr;
    logic [WS-1:0] dma_wdata, vcu_wdata, dma_rdata, vcu_rdata, bram_wdata, bram_rdata;
    logic [3:0]    dma_we, vcu_we, bram_we;
    logic          bram_en, vcu_memWRTDone, busy, irq_done, err_timeout, err_conflict;
    logic [2:0]    state;

    logic          t_RESET, t_start, t_dma_en;
    logic [AW-1:0] t_dma_addr, t_bram_addr;
    logic [WS-1:0] t_dma_rdata, t_vcu_rdata, t_bram_wdata;
    logic [3:0]    t_dma_we, t_bram_we;
    logic          t_bram_en, t_memwrt, t_busy, t_irq, t_err_timeout, t_err_conflict;
    logic [2:0]    t_state;

    int n_checks = 0;
    int n_errors = 0;

    vcu_bram_sched u_dut (
        .clk(clk), .RESET(RESET), .start(start), .abort(abort),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we), .dma_en(dma_en),
        .dma_rdata(dma_rdata),
        .vcu_addr(vcu_addr), .vcu_wdata(vcu_wdata), .vcu_we(vcu_we), .vcu_en(vcu_en),
        .vcu_rdata(vcu_rdata), .vcu_memWRTDone(vcu_memWRTDone), .vcu_done(vcu_done),
        .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_we(bram_we), .bram_en(bram_en),
        .bram_rdata(bram_rdata),
        .state(state), .busy(busy), .irq_done(irq_done),
        .err_timeout(err_timeout), .err_conflict(err_conflict)
    );

    vcu_bram_sched #(.LOAD_WORDS(4), .DRAIN_WORDS(4), .TIMEOUT(10)) u_dut_to (
        .clk(clk), .RESET(t_RESET), .start(t_start), .abort(1'b0),
        .dma_addr(t_dma_addr), .dma_wdata(32'h1234_5678), .dma_we(t_dma_we), .dma_en(t_dma_en),
        .dma_rdata(t_dma_rdata),
        .vcu_addr(32'd0), .vcu_wdata(32'd0), .vcu_we(4'd0), .vcu_en(1'b0),
        .vcu_rdata(t_vcu_rdata), .vcu_memWRTDone(t_memwrt), .vcu_done(1'b0),
        .bram_addr(t_bram_addr), .bram_wdata(t_bram_wdata), .bram_we(t_bram_we), .bram_en(t_bram_en),
        .bram_rdata(32'd0),
        .state(t_state), .busy(t_busy), .irq_done(t_irq),
        .err_timeout(t_err_timeout), .err_conflict(t_err_conflict)
    );

    // Behavioural BRAM behind the shared port: asynchronous read, byte-enabled write.
    logic [31:0] mem [0:1023];
    assign bram_rdata = mem[bram_addr[11:2]];
    always @(posedge clk) begin
        if (bram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bram_we[b]) mem[bram_addr[11:2]][8*b +: 8] <= bram_wdata[8*b +: 8];
            end
        end
    end

    function automatic logic [31:0] load_pat(int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] vcu_pat(int k);
        return 32'hC0DE_0000 | 32'(k);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: expected state transitions and expected DMA read data.
    logic [2:0]  exp_state_q [$];
    logic [31:0] exp_data_q [$];
    logic [2:0]  prev_state;
    bit          mon_en = 1'b0;
    int          irq_cnt = 0;

    always @(negedge clk) begin
        if (mon_en && (state !== prev_state)) begin
            if (exp_state_q.size() == 0) check("state_extra", 32'(state), 32'd8);
            else check("state_seq", 32'(state), 32'(exp_state_q.pop_front()));
        end
        if (mon_en && irq_done) irq_cnt++;
        prev_state = state;
    end

    task automatic load_words(input int n, input bit push_last);
        for (int i = 0; i < n; i++) begin
            dma_en    = 1'b1;
            dma_we    = 4'hF;
            dma_addr  = 32'(i) * 32'd4;
            dma_wdata = load_pat(i);
            if (push_last && (i == n - 1)) exp_state_q.push_back(3'd2);
            #1;
            if (push_last && (i == 0)) check("load_route", bram_addr, 32'd0);
            tick();
        end
        dma_en = 1'b0;
        dma_we = 4'd0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    int cnt;

    initial begin
        RESET = 1'b1; start = 1'b0; abort = 1'b0;
        dma_en = 1'b0; dma_we = 4'd0; dma_addr = '0; dma_wdata = '0;
        vcu_en = 1'b0; vcu_we = 4'd0; vcu_addr = '0; vcu_wdata = '0; vcu_done = 1'b0;
        t_RESET = 1'b1; t_start = 1'b0; t_dma_en = 1'b0; t_dma_we = 4'd0; t_dma_addr = '0;
        repeat (3) tick();

        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_irq", 32'(irq_done), 32'd0);
        check("rst_memwrt", 32'(vcu_memWRTDone), 32'd0);
        check("rst_errs", 32'({err_timeout, err_conflict}), 32'd0);
        check("rst_bram_en", 32'(bram_en), 32'd0);
        RESET = 1'b0; t_RESET = 1'b0;
        tick();

        // Full load / compute / drain transaction with the state scoreboard active.
        mon_en = 1'b1;
        irq_cnt = 0;
        exp_state_q.push_back(3'd1);
        pulse_start();
        check("load_busy", 32'(busy), 32'd1);
        load_words(512, 1'b1);
        check("compute_state", 32'(state), 32'd2);
        check("compute_memwrt", 32'(vcu_memWRTDone), 32'd1);
        vcu_addr = 32'h40;
        #1;
        check("vcu_owns_addr", bram_addr, 32'h40);
        for (int k = 0; k < 100; k++) begin
            vcu_en    = 1'b1;
            vcu_we    = 4'hF;
            vcu_addr  = 32'(k) * 32'd4;
            vcu_wdata = vcu_pat(k);
            vcu_done  = (k == 99);
            if (k == 99) exp_state_q.push_back(3'd3);
            #1;
            if (k == 0) begin
                check("vcu_rdata", vcu_rdata, load_pat(0));
                check("vcu_we_route", 32'(bram_we), 32'hF);
            end
            if (k == 50) check("memwrt_mid", 32'(vcu_memWRTDone), 32'd1);
            tick();
        end
        vcu_en = 1'b0; vcu_we = 4'd0; vcu_done = 1'b0;
        check("drain_state", 32'(state), 32'd3);
        check("drain_memwrt", 32'(vcu_memWRTDone), 32'd0);
        for (int w = 0; w < 256; w++) begin
            dma_en   = 1'b1;
            dma_we   = 4'd0;
            dma_addr = 32'(w) * 32'd4;
            exp_data_q.push_back((w < 100) ? vcu_pat(w) : load_pat(w));
            if (w == 255) begin
                exp_state_q.push_back(3'd4);
                exp_state_q.push_back(3'd0);
            end
            #1;
            check("drain_data", dma_rdata, exp_data_q.pop_front());
            if (w == 0) check("vcu_rdata_zero", vcu_rdata, 32'd0);
            tick();
        end
        dma_en = 1'b0;
        check("done_state", 32'(state), 32'd4);
        check("done_irq", 32'(irq_done), 32'd1);
        tick();
        check("idle_after_done", 32'(state), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        tick();
        mon_en = 1'b0;
        check("irq_cycles", 32'(irq_cnt), 32'd1);
        check("state_seq_left", 32'(exp_state_q.size()), 32'd0);
        check("no_errs", 32'({err_timeout, err_conflict}), 32'd0);

        // DMA access during COMPUTE: dropped and flagged until the next start.
        pulse_start();
        load_words(512, 1'b0);
        dma_en = 1'b1; dma_we = 4'd0; dma_addr = 32'd0; vcu_en = 1'b0;
        #1;
        check("conflict_bram_en", 32'(bram_en), 32'd0);
        check("conflict_rdata", dma_rdata, 32'd0);
        tick();
        dma_en = 1'b0;
        check("conflict_flag", 32'(err_conflict), 32'd1);
        check("conflict_stay", 32'(state), 32'd2);
        vcu_done = 1'b1;
        tick();
        vcu_done = 1'b0;
        pulse_abort();
        check("abort_drain", 32'(state), 32'd0);
        check("conflict_sticky", 32'(err_conflict), 32'd1);
        pulse_start();
        check("conflict_clear", 32'(err_conflict), 32'd0);
        pulse_abort();

        // abort and vcu_done together: abort wins, no DRAIN, no irq.
        pulse_start();
        load_words(512, 1'b0);
        abort = 1'b1; vcu_done = 1'b1;
        tick();
        abort = 1'b0; vcu_done = 1'b0;
        check("abort_done_state", 32'(state), 32'd0);
        check("abort_done_irq", 32'(irq_done), 32'd0);
        tick();
        check("abort_no_drain", 32'(state), 32'd0);
        check("abort_no_irq", 32'(irq_done), 32'd0);

        // RESET during COMPUTE drops vcu_memWRTDone before any clock edge.
        pulse_start();
        load_words(512, 1'b0);
        check("pre_rst_memwrt", 32'(vcu_memWRTDone), 32'd1);
        #1;
        RESET = 1'b1;
        #1;
        check("rst_async_memwrt", 32'(vcu_memWRTDone), 32'd0);
        check("rst_async_state", 32'(state), 32'd0);
        RESET = 1'b0;
        tick();

        // RESET at write 300 of LOAD, then a fresh load needs the full 512 writes.
        pulse_start();
        load_words(300, 1'b0);
        #1;
        RESET = 1'b1;
        #1;
        check("rst_mid_load", 32'(state), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        RESET = 1'b0;
        tick();
        pulse_start();
        load_words(511, 1'b0);
        check("reload_511", 32'(state), 32'd1);
        load_words(1, 1'b0);
        check("reload_512", 32'(state), 32'd2);
        pulse_abort();

        // Watchdog on the TIMEOUT=10 instance: exactly 10 COMPUTE cycles.
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t_dma_en = 1'b1; t_dma_we = 4'hF; t_dma_addr = 32'(i) * 32'd4;
            tick();
        end
        t_dma_en = 1'b0; t_dma_we = 4'd0;
        check("to_compute", 32'(t_state), 32'd2);
        cnt = 0;
        while ((t_state == 3'd2) && (cnt < 20)) begin
            cnt++;
            tick();
        end
        check("to_cycles", 32'(cnt), 32'd10);
        check("to_flag", 32'(t_err_timeout), 32'd1);
        check("to_idle", 32'(t_state), 32'd0);
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        check("to_clear", 32'(t_err_timeout), 32'd0);
        check("to_restart", 32'(t_state), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
